// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative MULTU/DIVU sequencer.
//   state_e      : sequencer states IDLE / RUN / DONE
//   OP_MULTU/DIVU: encoding of the op input
//   MULDIV_WIDTH : default operand width
package muldiv_pkg;

    localparam int unsigned MULDIV_WIDTH = 32;

    localparam logic OP_MULTU = 1'b0;
    localparam logic OP_DIVU  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration of shift-add multiply or restoring divide.
// Optional feature macro: MULDIV_DIVIDE_EN (adds the restoring-divide path).
// Ports:
//   acc_hi_i/acc_lo_i : current working registers
//   opnd_i            : multiplicand (MULTU) or divisor (DIVU)
//   op_i              : OP_MULTU / OP_DIVU
//   acc_hi_o/acc_lo_o : working registers after this iteration
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MULDIV_WIDTH
) (
    input  logic [WIDTH-1:0] acc_hi_i,
    input  logic [WIDTH-1:0] acc_lo_i,
    input  logic [WIDTH-1:0] opnd_i,
    input  logic             op_i,
    output logic [WIDTH-1:0] acc_hi_o,
    output logic [WIDTH-1:0] acc_lo_o
);

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi;
    logic [WIDTH-1:0] mul_lo;

    // Shift-add: conditionally add multiplicand, then shift {carry,hi,lo} right.
    always_comb begin
        mul_sum = {1'b0, acc_hi_i};
        if (acc_lo_i[0]) begin
            mul_sum = {1'b0, acc_hi_i} + {1'b0, opnd_i};
        end
        mul_hi = mul_sum[WIDTH:1];
        mul_lo = {mul_sum[0], acc_lo_i[WIDTH-1:1]};
    end

`ifdef MULDIV_DIVIDE_EN
    logic [WIDTH:0]   div_rem;
    logic [WIDTH:0]   div_trial;
    logic [WIDTH-1:0] div_hi;
    logic [WIDTH-1:0] div_lo;

    // Restoring divide: the shifted-out MSB of acc_hi is kept as bit WIDTH so
    // the trial subtraction sees the full partial remainder.
    always_comb begin
        div_rem   = {acc_hi_i, acc_lo_i[WIDTH-1]};
        div_trial = div_rem - {1'b0, opnd_i};
        if (!div_trial[WIDTH]) begin
            div_hi = div_trial[WIDTH-1:0];
            div_lo = {acc_lo_i[WIDTH-2:0], 1'b1};
        end else begin
            div_hi = div_rem[WIDTH-1:0];
            div_lo = {acc_lo_i[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        acc_hi_o = mul_hi;
        acc_lo_o = mul_lo;
        if (op_i == OP_DIVU) begin
            acc_hi_o = div_hi;
            acc_lo_o = div_lo;
        end
    end
`else
    // Multiply-only build: op never selects anything here.
    logic unused_op;
    assign unused_op = op_i;

    always_comb begin
        acc_hi_o = mul_hi;
        acc_lo_o = mul_lo;
    end
`endif

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULTU/DIVU controller owning the FSM, iteration counter,
// working registers and the architectural HI/LO registers.
// Optional feature macro: MULDIV_DIVIDE_EN (DIVU support; without it a DIVU
// start is ignored).
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start, op         : launch request and operation (OP_MULTU / OP_DIVU)
//   dataA, dataB      : rs / rt operands
//   flush             : abort in-flight operation
//   wr_hi, wr_lo      : MTHI / MTLO write enables, data on wdata
//   busy              : high while an operation is running
//   done              : one-cycle pulse when HI/LO were just committed
//   hi, lo            : architectural HI / LO
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MULDIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic             flush,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

`ifdef MULDIV_DIVIDE_EN
    localparam logic DIV_EN = 1'b1;
`else
    localparam logic DIV_EN = 1'b0;
`endif

    state_e           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic             start_legal;
    logic             accept;
    logic             stepping;
    logic             last_step;
    logic             commit;

    assign start_legal = start && ((op == OP_MULTU) || DIV_EN);
    assign accept      = start_legal && !flush && (state_q != RUN);
    assign stepping    = (state_q == RUN) && !flush;
    assign last_step   = (cnt_q == CNT_W'(WIDTH - 1));
    assign commit      = stepping && last_step;

    muldiv_step #(
        .WIDTH    (WIDTH)
    ) u_step (
        .acc_hi_i (acc_hi_q),
        .acc_lo_i (acc_lo_q),
        .opnd_i   (opnd_q),
        .op_i     (op_q),
        .acc_hi_o (step_hi),
        .acc_lo_o (step_lo)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides everything.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start_legal) state_d = RUN;
            RUN:  if (last_step)   state_d = DONE;
            DONE: state_d = start_legal ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
        end
    end

    // Output decode, registered so busy/done track the state register.
    always_comb begin
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // Datapath next-state: operand capture, iteration, commit and MTHI/MTLO.
    always_comb begin
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opnd_d   = opnd_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        if (accept) begin
            acc_hi_d = '0;
            acc_lo_d = (op == OP_DIVU) ? dataA : dataB;
            opnd_d   = (op == OP_DIVU) ? dataB : dataA;
            op_d     = op;
            cnt_d    = '0;
        end else if (stepping) begin
            acc_hi_d = step_hi;
            acc_lo_d = step_lo;
            cnt_d    = cnt_q + CNT_W'(1);
        end

        if (commit) begin
            hi_d = step_hi;
            lo_d = step_lo;
        end else if (state_q != RUN) begin
            if (wr_hi) hi_d = wdata;
            if (wr_lo) lo_d = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
            op_q     <= OP_MULTU;
            cnt_q    <= '0;
        end else begin
            busy_q   <= busy_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opnd_q   <= opnd_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: a cycle-level arithmetic model
// compared every cycle, plus directed vectors with literal expectations.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    localparam int unsigned W = 32;

`ifdef MULDIV_DIVIDE_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         op;
    logic [W-1:0] dataA;
    logic [W-1:0] dataB;
    logic         flush;
    logic         wr_hi;
    logic         wr_lo;
    logic [W-1:0] wdata;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    logic [W-1:0] last_hi = '0;
    logic [W-1:0] last_lo = '0;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .dataA (dataA),
        .dataB (dataB),
        .flush (flush),
        .wr_hi (wr_hi),
        .wr_lo (wr_lo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: remaining-cycle count and precomputed results.
    int           m_rem;
    logic         m_busy, m_done;
    logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
    logic [63:0]  prod;

    always @(posedge clk) begin
        if (rst) begin
            m_rem = 0; m_busy = 1'b0; m_done = 1'b0; m_hi = '0; m_lo = '0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                if (flush) begin
                    m_busy = 1'b0; m_rem = 0;
                end else begin
                    m_rem--;
                    if (m_rem == 0) begin
                        m_busy = 1'b0; m_done = 1'b1; m_hi = p_hi; m_lo = p_lo;
                    end
                end
            end else begin
                if (wr_hi) m_hi = wdata;
                if (wr_lo) m_lo = wdata;
                if (start && !flush && (op == OP_MULTU || DIV_EN)) begin
                    if (op == OP_MULTU) begin
                        prod = 64'(dataA) * 64'(dataB);
                        p_hi = prod[63:32]; p_lo = prod[31:0];
                    end else if (dataB == '0) begin
                        p_hi = dataA; p_lo = '1;
                    end else begin
                        p_hi = dataA % dataB; p_lo = dataA / dataB;
                    end
                    m_rem = W; m_busy = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc busy", 64'(busy), 64'(m_busy));
            chk("cyc done", 64'(done), 64'(m_done));
            chk("cyc hi",   64'(hi),   64'(m_hi));
            chk("cyc lo",   64'(lo),   64'(m_lo));
        end
    end

    // Launch at the current negedge; return at the done cycle (or after the bound).
    task automatic run_op(input string nm, input logic o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el);
        int n;
        bit seen;
        start = 1'b1; op = o; dataA = a; dataB = b;
        @(negedge clk);
        start = 1'b0;
        if (o == OP_DIVU && !DIV_EN) begin
            seen = 1'b0;
            repeat (W + 3) begin
                if (busy || done) seen = 1'b1;
                @(negedge clk);
            end
            chk({nm, " ignored"}, 64'(seen), 64'(0));
            chk({nm, " hi kept"}, 64'(hi), 64'(last_hi));
            chk({nm, " lo kept"}, 64'(lo), 64'(last_lo));
        end else begin
            n = 1;
            while (done !== 1'b1 && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk({nm, " latency"}, 64'(n), 64'(W + 1));
            chk({nm, " hi"}, 64'(hi), 64'(eh));
            chk({nm, " lo"}, 64'(lo), 64'(el));
            last_hi = eh; last_lo = el;
        end
    endtask

    initial begin
        int  n;
        bit  seen;
        rst = 1'b1; start = 1'b0; op = OP_MULTU; dataA = '0; dataB = '0;
        flush = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; wdata = '0;
        @(negedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("reset busy", 64'(busy), 64'(0));
        chk("reset done", 64'(done), 64'(0));
        chk("reset hi",   64'(hi),   64'(0));
        chk("reset lo",   64'(lo),   64'(0));

        // From IDLE, then chained launches from the DONE cycle.
        run_op("mul 6x7",     OP_MULTU, 32'd6,          32'd7,          32'h0,        32'h2A);
        run_op("mul max",     OP_MULTU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h1);
        run_op("mul 2^31x2",  OP_MULTU, 32'h8000_0000,  32'd2,          32'h1,        32'h0);
        run_op("mul 2^16sq",  OP_MULTU, 32'h0001_0000,  32'h0001_0000,  32'h1,        32'h0);
        run_op("div 100/7",   OP_DIVU,  32'd100,        32'd7,          32'd2,        32'd14);
        run_op("div 5/0",     OP_DIVU,  32'd5,          32'd0,          32'd5,        32'hFFFF_FFFF);
        run_op("div max/1",   OP_DIVU,  32'hFFFF_FFFF,  32'd1,          32'd0,        32'hFFFF_FFFF);
        run_op("div 7/100",   OP_DIVU,  32'd7,          32'd100,        32'd7,        32'd0);
        run_op("mul x1",      OP_MULTU, 32'hDEAD_BEEF,  32'd1,          32'h0,        32'hDEAD_BEEF);
        repeat (3) @(negedge clk);

        // Flush beats start in the same cycle.
        start = 1'b1; flush = 1'b1; op = OP_MULTU; dataA = 32'd3; dataB = 32'd3;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush over start busy", 64'(busy), 64'(0));

        // MTHI / MTLO preload, then flush an in-flight MULTU.
        wr_hi = 1'b1; wdata = 32'h1111;
        @(negedge clk);
        wr_hi = 1'b0; wr_lo = 1'b1; wdata = 32'h2222;
        @(negedge clk);
        wr_lo = 1'b0;
        chk("mthi", 64'(hi), 64'h1111);
        chk("mtlo", 64'(lo), 64'h2222);
        start = 1'b1; op = OP_MULTU; dataA = 32'd3; dataB = 32'd5;
        @(negedge clk);
        start = 1'b0;
        for (n = 1; n < 10; n++) begin
            if (n == 5) begin
                start = 1'b1; dataA = 32'd9; dataB = 32'd9;
                wr_hi = 1'b1; wdata = 32'hBAD0;
            end else begin
                start = 1'b0; wr_hi = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0; wr_hi = 1'b0;
        chk("busy before flush", 64'(busy), 64'(1));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush busy", 64'(busy), 64'(0));
        seen = 1'b0;
        repeat (W + 5) begin
            if (done || busy) seen = 1'b1;
            @(negedge clk);
        end
        chk("flush no done", 64'(seen), 64'(0));
        chk("flush hi kept", 64'(hi), 64'h1111);
        chk("flush lo kept", 64'(lo), 64'h2222);
        last_hi = 32'h1111; last_lo = 32'h2222;

        // Reset in the middle of an operation.
        start = 1'b1; op = DIV_EN ? OP_DIVU : OP_MULTU; dataA = 32'd1000; dataB = 32'd3;
        @(negedge clk);
        start = 1'b0;
        for (n = 1; n < 20; n++) @(negedge clk);
        chk("busy before rst", 64'(busy), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst busy", 64'(busy), 64'(0));
        chk("rst done", 64'(done), 64'(0));
        chk("rst hi",   64'(hi),   64'(0));
        chk("rst lo",   64'(lo),   64'(0));
        last_hi = '0; last_lo = '0;

        // DIVU from IDLE after reset (ignored in a multiply-only build).
        run_op("div after rst", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("mul b2b",       OP_MULTU, 32'd6, 32'd7, 32'h0, 32'h2A);
        repeat (3) @(negedge clk);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative multiply/divide controller for the EX stage of the pipelined MIPS-Lite CPU. It serves MULTU/DIVU, computing one radix-2 step per cycle over WIDTH cycles. Results go into architectural HI/LO registers, which feed MFHI/MFLO and accept MTHI/MTLO writes. While an operation runs it asserts `busy`, which hazard control uses to stall the pipeline.

## Interface
- `WIDTH`, 32, operand width; HI/LO are each WIDTH bits; iteration count equals WIDTH.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  launch request, qualified by `op`.
- `op`  in  1  0 = MULTU, 1 = DIVU.
- `dataA`  in  WIDTH  multiplicand / dividend (rs).
- `dataB`  in  WIDTH  multiplier / divisor (rt).
- `flush`  in  1  abort in-flight operation (branch/exception squash).
- `wr_hi`, `wr_lo`  in  1 each  MTHI / MTLO write enables.
- `wdata`  in  WIDTH  data for MTHI/MTLO.
- `busy`  out  1  high while state is RUN.
- `done`  out  1  one-cycle pulse when HI/LO have just been committed.
- `hi`, `lo`  out  WIDTH each  architectural HI/LO.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE/DONE + `start` (legal op) → RUN.
  - RUN with count = WIDTH-1 → DONE.
  - DONE without `start` → IDLE.
  - Any state + `flush` → IDLE.
- `start` is accepted only in IDLE or DONE. It is ignored in RUN, with no queueing.
- Operands are captured into working registers `acc_hi`/`acc_lo` on acceptance. Divisor or multiplicand is held in `opnd`. Iteration counter is log2(WIDTH)+1 bits, cleared on acceptance.
- MULTU, shift-add:
  - Init: `acc_hi` = 0, `acc_lo` = dataB.
  - Per step: if `acc_lo[0]`, compute {c, sum} = `acc_hi` + `opnd` (WIDTH+1 bits). Then shift {c or 0, sum or `acc_hi`, `acc_lo`} right by 1.
  - Final: hi = upper product, lo = lower product.
- DIVU, restoring:
  - Init: `acc_hi` = 0, `acc_lo` = dataA.
  - Per step: shift {`acc_hi`,`acc_lo`} left 1, then compute trial = `acc_hi` - `opnd` at WIDTH+1 bits.
  - If the trial is non-negative, `acc_hi` = trial and `acc_lo[0]` = 1; otherwise `acc_lo[0]` = 0.
  - Final: lo = quotient, hi = remainder.
- Divide by zero needs no special case: it yields lo = all-ones and hi = dividend.
- Commit: `hi`/`lo` load from `acc_hi`/`acc_lo` on the RUN→DONE edge only. Architectural HI/LO are never touched mid-operation.
- `wr_hi`/`wr_lo` update `hi`/`lo` only in IDLE or DONE. They are ignored in RUN. If a write coincides with an accepted `start`, the write takes effect and the operation still launches.
- `flush` in RUN discards the working registers. `hi`/`lo` keep their prior values, and `done` is not pulsed. `flush` has priority over `start` in the same cycle.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `hi` 0, `lo` 0, counter 0.
- `start` accepted at edge T:
  - `busy` = 1 during cycles T+1 … T+WIDTH.
  - Results are visible on `hi`/`lo` and `done` = 1 in cycle T+WIDTH+1, where `busy` = 0.
  - Latency is WIDTH+1 cycles.
- Back-to-back: `start` during the DONE cycle launches immediately, so the new `busy` rises the next cycle.
- `flush` or `rst` in RUN: `busy` = 0 from the next cycle.
  - `rst` also zeroes `hi`/`lo`.
  - `flush` leaves `hi`/`lo` untouched.
- `done` never lasts more than one cycle.

## Configuration
- `MULDIV_DIVIDE_EN` defined: DIVU supported as above.
- Not defined:
  - The restoring-divide datapath is omitted.
  - `start` with `op` = 1 is ignored: no state change, `busy` stays 0, HI/LO unchanged.
  - MULTU is unaffected.

## Structure
- `muldiv_pkg`: state enum (IDLE/RUN/DONE), op codes `OP_MULTU` = 1'b0 and `OP_DIVU` = 1'b1, and the default WIDTH constant.
- Sub-module `muldiv_step`: combinational single-iteration datapath. It takes `acc_hi`, `acc_lo`, `opnd` and `op`, and returns the next `acc_hi`/`acc_lo`.
- The sequencer owns the FSM, counter, working registers and HI/LO.

## Test plan
- MULTU 6 × 7 → after 33 cycles, `done` pulse, lo = 0x0000002A, hi = 0.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi = 0xFFFFFFFE, lo = 0x00000001.
- DIVU 100 / 7 → lo = 14, hi = 2.
- DIVU 5 / 0 → lo = 0xFFFFFFFF, hi = 5.
- Preload hi/lo via MTHI/MTLO = 0x1111/0x2222, then start MULTU and assert `flush` at cycle 10:
  - `busy` falls next cycle, no `done`, hi/lo remain 0x1111/0x2222.
  - A second `start` issued mid-RUN is ignored.
- `rst` asserted at cycle 20 of a DIVU → state IDLE, hi = lo = 0, `busy` 0 next cycle.
- Back-to-back: `start` during DONE → second result after exactly 33 more cycles.
- Without `MULDIV_DIVIDE_EN`, DIVU `start` → `busy` stays 0.
